// File: rtl/mac_accumulator8.sv
// Multiply-accumulate wrapper: accepts TERMS operand pairs, multiplies each through the
// carry-save multiplier and presents the dot-product sum. Define MAC_SATURATE_EN to clamp on overflow.

module wallaceTreeMultiplier8Bit (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product
);

  // Partial-product rows reduced by 3:2 compressors; sum and carry vectors meet in one final add
  always_comb begin : reduce
    logic [15:0] sum_v;
    logic [15:0] carry_v;
    logic [15:0] pp_v;
    logic [15:0] next_v;
    sum_v   = 16'd0;
    carry_v = 16'd0;
    for (int i = 0; i < 8; i++) begin
      pp_v    = b[i] ? (16'(a) << i) : 16'd0;
      next_v  = sum_v ^ carry_v ^ pp_v;
      carry_v = ((sum_v & carry_v) | (sum_v & pp_v) | (carry_v & pp_v)) << 1;
      sum_v   = next_v;
    end
    product = sum_v + carry_v;
  end

endmodule

module mac_accumulator8 #(
  parameter int ACC_W = 24,
  parameter int TERMS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow
);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic [7:0]       TERMS_C = 8'(TERMS);
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  state_t           state_q, state_d;
  logic [7:0]       in_cnt_q, in_cnt_d;
  logic [7:0]       acc_cnt_q, acc_cnt_d;
  logic [15:0]      p_q, p_d;
  logic             p_valid_q, p_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      prod_s;
  logic [ACC_W:0]   acc_sum_s;
  logic             accept_s;

  wallaceTreeMultiplier8Bit u_mult (
    .a       (a),
    .b       (b),
    .product (prod_s)
  );

  assign in_ready  = (state_q == ACCUM) && (in_cnt_q < TERMS_C);
  assign accept_s  = in_valid && in_ready;
  // Extra top bit captures the carry out of the accumulator
  assign acc_sum_s = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, p_q};

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    p_d         = p_q;
    p_valid_d   = 1'b0;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      state_d     = ACCUM;
      in_cnt_d    = 8'd0;
      acc_cnt_d   = 8'd0;
      p_d         = 16'd0;
      acc_d       = {ACC_W{1'b0}};
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (accept_s) begin
        p_d       = prod_s;
        p_valid_d = 1'b1;
        in_cnt_d  = in_cnt_q + 8'd1;
      end else begin
        p_valid_d = 1'b0;
      end

      case (state_q)
        ACCUM: begin
          if (p_valid_q) begin
            ovf_d     = ovf_q | acc_sum_s[ACC_W];
`ifdef MAC_SATURATE_EN
            acc_d     = ovf_d ? ACC_MAX : acc_sum_s[ACC_W-1:0];
`else
            acc_d     = acc_sum_s[ACC_W-1:0];
`endif
            acc_cnt_d = acc_cnt_q + 8'd1;
            if (acc_cnt_d == TERMS_C) begin
              state_d     = DONE;
              out_valid_d = 1'b1;
            end else begin
              state_d     = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        DONE: begin
          // Result held until taken; the handshake rearms the next dot product
          if (out_valid_q && out_ready) begin
            state_d     = ACCUM;
            in_cnt_d    = 8'd0;
            acc_cnt_d   = 8'd0;
            acc_d       = {ACC_W{1'b0}};
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      in_cnt_q    <= 8'd0;
      acc_cnt_q   <= 8'd0;
      p_q         <= 16'd0;
      p_valid_q   <= 1'b0;
      acc_q       <= {ACC_W{1'b0}};
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;

endmodule
